// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package for the hazard controller:
// FSM state encoding, down-counter width and counter saturation value.
package hazard_ctrl_pkg;

  localparam int          CNT_W   = 2;
  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LD_STALL = 2'd1,
    S_BR_FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter16.sv
// 16-bit saturating event counter, updates on the falling clock edge.
// Ports: i_clk, i_rst (sync, high), i_inc (count enable), o_count.
module sat_counter16
  import hazard_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != SAT_MAX)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/exception flushes.
// Ports: clock/reset, ID/EX hazard info in; holds, flushes, perf counters out.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES    = 1,
  parameter int unsigned BR_FLUSH_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  iID_ra_addr,
  input  logic [4:0]  iID_rb_addr,
  input  logic        iID_use_ra,
  input  logic        iID_use_rb,
  input  logic        iEX_do_dm_read,
  input  logic        iEX_do_reg_write,
  input  logic [4:0]  iEX_write_reg_addr,
  input  logic        iEX_branch_taken,
  input  logic        iFlush_all,
  output logic        oHold_pc,
  output logic        oHold_REG1,
  output logic        do_flush_REG1,
  output logic        do_flush_REG2,
  output logic        do_flush_REG3,
  output logic        do_flush_REG4,
  output logic [15:0] oStall_count,
  output logic [15:0] oFlush_count
);

  localparam cnt_t LD_INIT = cnt_t'(LOAD_BUBBLES - 1);
  localparam cnt_t BR_INIT = cnt_t'(BR_FLUSH_CYCLES - 1);

  hz_state_e r_state, w_state_n;
  cnt_t      r_cnt, w_cnt_n;
  logic      w_load_use;
  logic      w_br_acc;
  logic      w_hold;

  assign w_load_use = iEX_do_dm_read & iEX_do_reg_write &
                      (iEX_write_reg_addr != 5'd0) &
                      ((iID_use_ra & (iID_ra_addr == iEX_write_reg_addr)) |
                       (iID_use_rb & (iID_rb_addr == iEX_write_reg_addr)));

  assign w_br_acc = ~reset & ~iFlush_all & iEX_branch_taken;

  always_ff @(negedge clock) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_hold        = 1'b0;
    do_flush_REG1 = 1'b0;
    do_flush_REG2 = 1'b0;
    do_flush_REG3 = 1'b0;
    do_flush_REG4 = 1'b0;
    if (reset || iFlush_all) begin
      do_flush_REG1 = 1'b1;
      do_flush_REG2 = 1'b1;
      do_flush_REG3 = 1'b1;
      do_flush_REG4 = 1'b1;
      w_state_n     = S_RUN;
      w_cnt_n       = '0;
    end else if (iEX_branch_taken) begin
      // A taken branch restarts from any state, aborting a stall.
      do_flush_REG1 = 1'b1;
      do_flush_REG2 = 1'b1;
      if (BR_FLUSH_CYCLES > 1) begin
        w_state_n = S_BR_FLUSH;
        w_cnt_n   = BR_INIT;
      end else begin
        w_state_n = S_RUN;
        w_cnt_n   = '0;
      end
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_load_use) begin
            w_hold        = 1'b1;
            do_flush_REG2 = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              w_state_n = S_LD_STALL;
              w_cnt_n   = LD_INIT;
            end
          end
        end
        S_LD_STALL: begin
          // Bubble count is fixed once started; load_use is ignored.
          w_hold        = 1'b1;
          do_flush_REG2 = 1'b1;
          if (r_cnt == cnt_t'(1)) begin
            w_state_n = S_RUN;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt - cnt_t'(1);
          end
        end
        S_BR_FLUSH: begin
          do_flush_REG1 = 1'b1;
          if (r_cnt == cnt_t'(1)) begin
            w_state_n = S_RUN;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt - cnt_t'(1);
          end
        end
        default: begin
          w_state_n = S_RUN;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  assign oHold_pc   = w_hold;
  assign oHold_REG1 = w_hold;

  sat_counter16 u_stall_cnt (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_inc   (w_hold),
    .o_count (oStall_count)
  );

  sat_counter16 u_flush_cnt (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_inc   (w_br_acc),
    .o_count (oFlush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three parameterisations in parallel,
// directed scenarios plus random traffic against a bubble-budget model.
module tb_hazard_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [4:0] ra, rb, wa;
  logic       ura, urb, ld, wr, br, fa;

  logic [2:0]  hp, hr, f1, f2, f3, f4;
  logic [15:0] sc [3];
  logic [15:0] fc [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(
      .LOAD_BUBBLES    (g == 0 ? 1 : (g == 1 ? 3 : 2)),
      .BR_FLUSH_CYCLES (g == 0 ? 1 : (g == 1 ? 2 : 3))
    ) u_dut (
      .clock              (clock),
      .reset              (reset),
      .iID_ra_addr        (ra),
      .iID_rb_addr        (rb),
      .iID_use_ra         (ura),
      .iID_use_rb         (urb),
      .iEX_do_dm_read     (ld),
      .iEX_do_reg_write   (wr),
      .iEX_write_reg_addr (wa),
      .iEX_branch_taken   (br),
      .iFlush_all         (fa),
      .oHold_pc           (hp[g]),
      .oHold_REG1         (hr[g]),
      .do_flush_REG1      (f1[g]),
      .do_flush_REG2      (f2[g]),
      .do_flush_REG3      (f3[g]),
      .do_flush_REG4      (f4[g]),
      .oStall_count       (sc[g]),
      .oFlush_count       (fc[g])
    );
  end

  int ntests = 0;
  int nfail  = 0;

  int lbv [3] = '{1, 3, 2};
  int brv [3] = '{1, 2, 3};
  int hl  [3] = '{0, 0, 0};
  int fl  [3] = '{0, 0, 0};
  int ms  [3] = '{0, 0, 0};
  int mf  [3] = '{0, 0, 0};

  task automatic drv(input logic [4:0] a, input logic [4:0] b,
                     input logic ua, input logic ub,
                     input logic l, input logic w, input logic [4:0] d,
                     input logic bt, input logic f, input logic r);
    ra = a; rb = b; ura = ua; urb = ub;
    ld = l; wr = w; wa = d; br = bt; fa = f; reset = r;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc(input bit chk);
    logic [5:0] e   [3];
    logic [5:0] got;
    bit         hd  [3];
    bit         bi  [3];
    bit         luse;
    @(posedge clock);
    #1;
    luse = ld && wr && (wa != 0) &&
           ((ura && ra == wa) || (urb && rb == wa));
    for (int i = 0; i < 3; i++) begin
      hd[i] = 0;
      bi[i] = 0;
      if (reset || fa) begin
        e[i] = 6'b001111;
        hl[i] = 0; fl[i] = 0;
      end else if (br) begin
        e[i] = 6'b001100;
        bi[i] = 1;
        fl[i] = brv[i] - 1; hl[i] = 0;
      end else if (fl[i] > 0) begin
        e[i] = 6'b001000;
        fl[i]--;
      end else if (hl[i] > 0) begin
        e[i] = 6'b110100;
        hd[i] = 1;
        hl[i]--;
      end else if (luse) begin
        e[i] = 6'b110100;
        hd[i] = 1;
        hl[i] = lbv[i] - 1;
      end else begin
        e[i] = 6'b000000;
      end
      if (chk) begin
        got = {hp[i], hr[i], f1[i], f2[i], f3[i], f4[i]};
        ntests++;
        assert (got === e[i]) else begin
          nfail++;
          $error("FAIL outs[%0d] got %b exp %b", i, got, e[i]);
        end
        ntests++;
        assert (sc[i] === 16'(ms[i])) else begin
          nfail++;
          $error("FAIL stall_cnt[%0d] got %0d exp %0d", i, sc[i], ms[i]);
        end
        ntests++;
        assert (fc[i] === 16'(mf[i])) else begin
          nfail++;
          $error("FAIL flush_cnt[%0d] got %0d exp %0d", i, fc[i], mf[i]);
        end
      end
    end
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        ms[i] = 0; mf[i] = 0;
      end else begin
        if (hd[i] && ms[i] < 65535) ms[i]++;
        if (bi[i] && mf[i] < 65535) mf[i]++;
      end
    end
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0);
    cyc(1);
    cyc(1);
    idle();
    cyc(1);
    cyc(1);

    // load r3, dependent use of r3 on ra
    drv(3, 7, 1, 0, 1, 1, 3, 0, 0, 0);
    cyc(1);
    idle();
    repeat (4) cyc(1);

    // dependent use on rb
    drv(9, 5, 0, 1, 1, 1, 5, 0, 0, 0);
    cyc(1);
    idle();
    repeat (4) cyc(1);

    // r0 destination never stalls
    drv(0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    cyc(1);
    // matching rb that is not read
    drv(1, 4, 1, 0, 1, 1, 4, 0, 0, 0);
    cyc(1);
    // non-load writer
    drv(4, 4, 1, 1, 0, 1, 4, 0, 0, 0);
    cyc(1);
    idle();
    cyc(1);

    // taken branch
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1);
    idle();
    repeat (4) cyc(1);

    // load_use with taken branch in the same cycle
    drv(6, 0, 1, 0, 1, 1, 6, 1, 0, 0);
    cyc(1);
    idle();
    repeat (4) cyc(1);

    // branch aborts a running stall
    drv(8, 0, 1, 0, 1, 1, 8, 0, 0, 0);
    cyc(1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1);
    idle();
    repeat (4) cyc(1);

    // flush_all during branch flush, and over load_use
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1);
    drv(2, 0, 1, 0, 1, 1, 2, 0, 1, 0);
    cyc(1);
    idle();
    repeat (3) cyc(1);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      drv(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 3)),
          1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 31) == 0),
          1'($urandom_range(0, 63) == 0));
      cyc(1);
    end
    idle();
    repeat (4) cyc(1);

    // reset in the middle of a stall sequence
    drv(3, 0, 1, 0, 1, 1, 3, 0, 0, 0);
    cyc(1);
    idle();
    cyc(1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1);
    cyc(1);
    idle();
    repeat (4) cyc(1);

    // long stall run saturates the stall counter
    drv(3, 0, 1, 0, 1, 1, 3, 0, 0, 0);
    repeat (70000) cyc(0);
    cyc(1);
    idle();
    repeat (4) cyc(1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
